// File: rtl/modbus_rx_frame_pkg.sv
// Modbus RTU constants and types shared by the request receiver and the response builder.
package modbus_rx_frame_pkg;

  localparam logic [15:0] CRC_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC_POLY   = 16'hA001;  // 0x8005 reflected
  localparam logic [7:0]  BCAST_ADDR = 8'h00;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CRC  = 2'b01;
  localparam logic [1:0] ERR_LEN  = 2'b10;
  localparam logic [1:0] ERR_GAP  = 2'b11;

  localparam int unsigned FRAME_LEN = 8;   // addr, func, 2x16-bit field, 16-bit CRC
  localparam int unsigned HDR_LEN   = 6;   // bytes preceding the CRC
  localparam int unsigned CHAR_BITS = 11;  // start + 8 data + parity/stop + stop

  typedef enum logic [1:0] {
    StWaitIdle,
    StIdle,
    StRecv,
    StCheck
  } rx_state_e;

endpackage

// File: rtl/crc16_modbus_serial.sv
// Bit-serial CRC-16/MODBUS engine, one byte per 8 clocks.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   start_i      : accept data_i (ignored while busy_o)
//   init_i       : with start_i, restart the running CRC from CRC_INIT
//   data_i       : byte to fold into the CRC
//   busy_o       : high for the 8 shift clocks after a start
//   crc_o        : running CRC register
module crc16_modbus_serial
  import modbus_rx_frame_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        init_i,
  input  logic [7:0]  data_i,
  output logic        busy_o,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;

  assign busy_o = (bit_cnt_q != 4'd0);
  assign crc_o  = crc_q;

  always_comb begin
    crc_d     = crc_q;
    bit_cnt_d = bit_cnt_q;
    if (busy_o) begin
      crc_d     = crc_q[0] ? ((crc_q >> 1) ^ CRC_POLY) : (crc_q >> 1);
      bit_cnt_d = bit_cnt_q - 4'd1;
    end else if (start_i) begin
      crc_d     = (init_i ? CRC_INIT : crc_q) ^ {8'h00, data_i};
      bit_cnt_d = 4'd8;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q     <= CRC_INIT;
      bit_cnt_q <= 4'd0;
    end else begin
      crc_q     <= crc_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/modbus_rx_frame.sv
// Modbus RTU request receiver: frames bytes by t1.5/t3.5 silence, checks CRC, filters on
// slave address and presents the decoded 8-byte request.
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   rx_byte_valid, rx_byte     : byte strobe and data from the UART receiver
//   tx_busy                    : our transmitter owns the bus; received bytes are echoes
//   frame_valid                : 1-cycle pulse, good addressed request; fields below held
//   frame_func/addr/data/bcast : decoded request fields
//   frame_err, err_code        : 1-cycle pulse for a dropped addressed frame; code held
module modbus_rx_frame
  import modbus_rx_frame_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter logic [7:0]  DEV_ADDR  = 8'h01,
  parameter int unsigned T15_BITS  = 28,
  parameter int unsigned T35_BITS  = 39
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_byte_valid,
  input  logic [7:0]  rx_byte,
  input  logic        tx_busy,
  output logic        frame_valid,
  output logic [7:0]  frame_func,
  output logic [15:0] frame_addr,
  output logic [15:0] frame_data,
  output logic        frame_bcast,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  localparam int unsigned BPS     = CLK_FREQ / BAUD_RATE;
  localparam int unsigned T15_CNT = T15_BITS * BPS;
  localparam int unsigned T35_CNT = T35_BITS * BPS;
  localparam int unsigned GapW    = $clog2(T35_CNT + 1);

  localparam logic [GapW-1:0] T15_LIM = GapW'(T15_CNT);
  localparam logic [GapW-1:0] T35_LIM = GapW'(T35_CNT);
  localparam logic [3:0]      HDR_N   = 4'(HDR_LEN);
  localparam logic [3:0]      LEN_N   = 4'(FRAME_LEN);
  localparam logic [3:0]      CNT_MAX = 4'(FRAME_LEN + 1);  // 9 marks overrun

  rx_state_e                  state_q, state_d;
  logic [GapW-1:0]            gap_cnt_q, gap_cnt_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [HDR_LEN-1:0][7:0]    hdr_q, hdr_d;
  logic                       gap_err_q, gap_err_d;
  logic                       pend_q, pend_d;
  logic [7:0]                 pend_byte_q, pend_byte_d;
  logic                       valid_q, valid_d;
  logic                       err_q, err_d;
  logic [1:0]                 code_q, code_d;
  logic [7:0]                 func_q, func_d;
  logic [15:0]                addr_q, addr_d;
  logic [15:0]                data_q, data_d;
  logic                       bcast_q, bcast_d;

  logic                       crc_start, crc_init, crc_busy;
  logic [7:0]                 crc_data;
  logic [15:0]                crc_val;
  logic                       gap_t35, addressed;

  crc16_modbus_serial u_crc (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (crc_start),
    .init_i  (crc_init),
    .data_i  (crc_data),
    .busy_o  (crc_busy),
    .crc_o   (crc_val)
  );

  assign gap_t35   = (gap_cnt_q == T35_LIM);
  assign addressed = (hdr_q[0] == DEV_ADDR) || (hdr_q[0] == BCAST_ADDR);

  always_comb begin
    gap_cnt_d = rx_byte_valid ? '0 : (gap_t35 ? gap_cnt_q : gap_cnt_q + 1'b1);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    gap_err_d   = gap_err_q;
    pend_d      = pend_q;
    pend_byte_d = pend_byte_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    code_d      = code_q;
    func_d      = func_q;
    addr_d      = addr_q;
    data_d      = data_q;
    bcast_d     = bcast_q;
    crc_start   = 1'b0;
    crc_init    = 1'b0;
    crc_data    = rx_byte;

    unique case (state_q)
      StWaitIdle: begin
        pend_d = 1'b0;
        if (gap_t35) state_d = StIdle;
      end

      StIdle: begin
        pend_d = 1'b0;
        if (pend_q) begin
          // Byte that collided with the previous frame's close
          hdr_d[0]  = pend_byte_q;
          crc_data  = pend_byte_q;
          cnt_d     = 4'd1;
          gap_err_d = 1'b0;
          crc_start = 1'b1;
          crc_init  = 1'b1;
          state_d   = StRecv;
        end else if (rx_byte_valid && tx_busy) begin
          // Our own echo: re-arm only after the bus goes silent again
          state_d = StWaitIdle;
        end else if (rx_byte_valid) begin
          hdr_d[0]  = rx_byte;
          cnt_d     = 4'd1;
          gap_err_d = 1'b0;
          crc_start = 1'b1;
          crc_init  = 1'b1;
          state_d   = StRecv;
        end
      end

      StRecv: begin
        if (tx_busy) begin
          state_d = StWaitIdle;
        end else if (gap_t35) begin
          state_d = StCheck;
          if (rx_byte_valid) begin
            pend_d      = 1'b1;
            pend_byte_d = rx_byte;
          end
        end else if (rx_byte_valid) begin
          if (gap_cnt_q > T15_LIM) gap_err_d = 1'b1;
          if (cnt_q < HDR_N) hdr_d[cnt_q[2:0]] = rx_byte;
          if (cnt_q < LEN_N) crc_start = 1'b1;
          if (cnt_q < CNT_MAX) cnt_d = cnt_q + 4'd1;
        end
      end

      StCheck: begin
        state_d = StIdle;
        if (addressed) begin
          if (gap_err_q) begin
            err_d  = 1'b1;
            code_d = ERR_GAP;
          end else if (cnt_q != LEN_N) begin
            err_d  = 1'b1;
            code_d = ERR_LEN;
          end else if (crc_busy || (crc_val != 16'h0000)) begin
            err_d  = 1'b1;
            code_d = ERR_CRC;
          end else begin
            valid_d = 1'b1;
            func_d  = hdr_q[1];
            addr_d  = {hdr_q[2], hdr_q[3]};
            data_d  = {hdr_q[4], hdr_q[5]};
            bcast_d = (hdr_q[0] == BCAST_ADDR);
          end
        end
      end

      default: state_d = StWaitIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StWaitIdle;
      gap_cnt_q   <= '0;
      cnt_q       <= 4'd0;
      hdr_q       <= '0;
      gap_err_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_byte_q <= 8'h00;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= ERR_NONE;
      func_q      <= 8'h00;
      addr_q      <= 16'h0000;
      data_q      <= 16'h0000;
      bcast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      gap_err_q   <= gap_err_d;
      pend_q      <= pend_d;
      pend_byte_q <= pend_byte_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      code_q      <= code_d;
      func_q      <= func_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      bcast_q     <= bcast_d;
    end
  end

  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign err_code    = code_q;
  assign frame_func  = func_q;
  assign frame_addr  = addr_q;
  assign frame_data  = data_q;
  assign frame_bcast = bcast_q;

endmodule
